sha256_msg_padder: RTL
======================

Name: sha256_msg_padder

Overview:
Upstream feeder for the SHA-256 compression core. It accepts an arbitrary-length byte message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and the 64-bit bit length. It emits complete 512-bit blocks over a valid/ready handshake, and flags the first and last block of each message so the core can reload the initial hash values and know when to present the final digest.

Parameters:
LEN_W, 64, width of the message bit-length counter and of the appended length field (fixed by the standard; not meant to be overridden).
WORDS, 16, 32-bit words per block.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_data  in  32  message word, big-endian; byte 0 is in_data[31:24].
in_valid  in  1  in_data is valid.
in_last  in  1  this word ends the message.
in_nbytes  in  3  valid bytes in a last word, 0..4; ignored (treated as 4) when in_last=0.
in_ready  out  1  padder accepts a word this cycle.
block_out  out  512  padded block; word 0 is in [511:480].
block_valid  out  1  block_out is stable and complete.
block_first  out  1  block is the first block of a message; qualified by block_valid.
block_last  out  1  block is the final padded block; qualified by block_valid.
block_ready  in  1  consumer takes the block.

Behaviour:
- Reset (reset=0, asynchronous): state=FILL, word index=0, byte count=0, first flag=1, pad-pending=0, buffer cleared. in_ready=0 during reset. After reset, in_ready=1, and block_valid, block_first and block_last are 0.
- State machine: FILL, PAD, LEN, EMIT.
- FILL:
  - in_ready=1; a word is accepted on in_valid&in_ready and written to buffer[idx], then idx increments. Byte count increments by 4, or by in_nbytes on the last word.
  - When idx reaches 16 on a non-last word, go to EMIT with last=0.
  - On the last word, the unused low bytes are zeroed. If in_nbytes<4, byte position in_nbytes is set to 0x80. If in_nbytes=4, pad-pending=1.
  - On the last word, go to PAD. If the last word filled word 15, go to EMIT first (last=0) and continue to PAD afterwards.
- PAD:
  - in_ready=0; one buffer word is written per cycle.
  - The word is 0x80000000 if pad-pending (which then clears), otherwise 0.
  - Continue until idx=14, then go to LEN.
  - If PAD is entered with idx>14, or the 0x80 word lands at idx 14 or 15, fill to 16, go to EMIT with last=0, and return to PAD on a fresh block from idx=0.
- LEN: two cycles. Word 14 = bit length [63:32], word 15 = bit length [31:0], where bit length = byte count<<3, truncated to 64 bits. Then go to EMIT with last=1.
- EMIT:
  - block_valid=1 and in_ready=0.
  - block_out, block_first and block_last are held stable until block_valid&block_ready.
  - On the handshake: idx=0 and first=0. If last=1, also set first=1, byte count=0, then go to FILL. Otherwise return to the pending state (FILL or PAD).
- Throughput: one input word per cycle in FILL, with no bubble except during EMIT and the PAD/LEN cycles.
- in_valid is ignored whenever in_ready=0.
- block_ready may be held high continuously; at most one block is transferred per EMIT entry.
- Boundary cases:
  - Empty message: in_last with in_nbytes=0 produces a single block with word 0 = 0x80000000.
  - A message of 56..63 bytes produces two blocks.
  - A non-last word with in_nbytes!=4 is treated as 4.
- Reset asserted mid-block discards all partial state. No block is emitted after reset deasserts until new words arrive.

Test Plan:
- "abc": one word 0x61626300, in_nbytes=3, last → one block with block_first=1 and block_last=1; word0=0x61626380, words1..14=0, word15=0x00000018. Feeding this block to the SHA-256 core gives digest ba7816bf...f20015ad.
- Empty message: in_last=1, in_nbytes=0 → one block; word0=0x80000000, all other words 0, first=1, last=1.
- 55 bytes (13 full words + a 3-byte last word) → one block; word13 low byte=0x80, word14=0, word15=0x000001B8.
- 56 bytes (14 full words, last word in_nbytes=4) → block A: word14=0x80000000, word15=0, first=1, last=0. Block B: words0..13=0, word15=0x000001C0, first=0, last=1.
- 64 bytes → block A carries the data (last=0). Block B: word0=0x80000000, word15=0x00000200, last=1. Back-to-back messages: the next message's first block has block_first=1.
- Backpressure and reset:
  - Hold block_ready=0 for 10 cycles in EMIT → block_valid stays 1, block_out is unchanged, in_ready=0, and in_valid words are not consumed.
  - Assert reset mid-FILL after 5 words → outputs go to their reset values immediately. A following "abc" yields the exact "abc" block above.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: packs a big-endian word stream into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit bit length, and tags first/last blocks.
module sha256_msg_padder #(
    parameter int LEN_W = 64,
    parameter int WORDS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [2:0]            in_nbytes,
    output logic                  in_ready,
    output logic [WORDS*32-1:0]   block_out,
    output logic                  block_valid,
    output logic                  block_first,
    output logic                  block_last,
    input  logic                  block_ready
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        LEN  = 2'd2,
        EMIT = 2'd3
    } state_t;

    localparam logic [4:0] IDX_LEN_HI = 5'd14;
    localparam logic [4:0] IDX_PAD_END = 5'd13;
    localparam logic [4:0] IDX_LAST = 5'(WORDS - 1);

    state_t             state;
    state_t             state_nxt;
    state_t             resume;
    logic [4:0]         idx;
    logic [LEN_W-1:0]   byte_cnt;
    logic [LEN_W-1:0]   bit_len;
    logic               first_flag;
    logic               last_blk;
    logic               pad_pending;
    logic [31:0]        buf_q [WORDS];

    logic               take;
    logic [2:0]         nb;
    logic [31:0]        word_in;
    logic               pad_skip;

    // Valid/ready: a word moves on the rising edge where in_valid and in_ready are
    // both high; a block moves where block_valid and block_ready are both high.
    assign take     = in_valid & in_ready;
    assign nb       = (!in_last || in_nbytes >= 3'd4) ? 3'd4 : in_nbytes;
    assign bit_len  = {byte_cnt[LEN_W-4:0], 3'b000};
    // Entering PAD at word 14 with no pending marker leaves nothing to pad.
    assign pad_skip = (idx == IDX_LEN_HI) && !pad_pending;

    // Unused trailing bytes are dropped and the 0x80 marker lands right after the data.
    always_comb begin
        word_in = in_data;
        case (nb)
            3'd0:    word_in = 32'h8000_0000;
            3'd1:    word_in = {in_data[31:24], 24'h80_0000};
            3'd2:    word_in = {in_data[31:16], 16'h8000};
            3'd3:    word_in = {in_data[31:8], 8'h80};
            default: word_in = in_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (take) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = EMIT;
                    end else if (in_last) begin
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                if (pad_skip || idx == IDX_PAD_END) begin
                    state_nxt = LEN;
                end else if (idx == IDX_LAST) begin
                    state_nxt = EMIT;
                end
            end
            LEN: begin
                if (idx == IDX_LAST) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (block_ready) begin
                    state_nxt = last_blk ? FILL : resume;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_ready    = reset && (state == FILL);
        block_valid = (state == EMIT);
        block_first = (state == EMIT) && first_flag;
        block_last  = (state == EMIT) && last_blk;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            byte_cnt    <= '0;
            first_flag  <= 1'b1;
            last_blk    <= 1'b0;
            pad_pending <= 1'b0;
            resume      <= FILL;
            for (int i = 0; i < WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (take) begin
                        buf_q[idx[3:0]] <= word_in;
                        idx             <= idx + 5'd1;
                        byte_cnt        <= byte_cnt + LEN_W'(nb);
                        if (in_last) begin
                            pad_pending <= (nb == 3'd4);
                        end
                        if (idx == IDX_LAST) begin
                            last_blk <= 1'b0;
                            resume   <= in_last ? PAD : FILL;
                        end
                    end
                end
                PAD: begin
                    if (!pad_skip) begin
                        buf_q[idx[3:0]] <= pad_pending ? 32'h8000_0000 : 32'h0;
                        pad_pending     <= 1'b0;
                        idx             <= idx + 5'd1;
                        // Marker or data spilled into word 14/15: flush and pad a fresh block.
                        if (idx == IDX_LAST) begin
                            last_blk <= 1'b0;
                            resume   <= PAD;
                        end
                    end
                end
                LEN: begin
                    buf_q[idx[3:0]] <= (idx == IDX_LEN_HI) ? bit_len[63:32] : bit_len[31:0];
                    idx             <= idx + 5'd1;
                    if (idx == IDX_LAST) begin
                        last_blk <= 1'b1;
                    end
                end
                EMIT: begin
                    if (block_ready) begin
                        idx        <= '0;
                        first_flag <= last_blk;
                        if (last_blk) begin
                            byte_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        block_out = '0;
        for (int i = 0; i < WORDS; i++) begin
            block_out[32*(WORDS-1-i) +: 32] = buf_q[i];
        end
    end

endmodule
